dense_seq_ctrl: RTL and testbench
=================================

Name: dense_seq_ctrl

Overview:
- Sequences the dense embedding block over a full character string of N_CHAR characters.
- For each character it presents the code to the dense block, runs it, and captures the HID_DIM x N_LEN embedding.
- Assembles all embeddings into one output vector for the downstream layer.
- Sits between the character input stage and the first hidden layer.
- Uses the same level-held run/valid handshake as the rest of the datapath.

Parameters:
- N_CHAR, 10: characters per string.
- CHAR_LEN, 8: bits per character code.
- HID_DIM, 24: embedding elements per character.
- N_LEN, 16: bits per element (fixed point).
- TIMEOUT, 15: max RUN cycles to wait for dense_valid before error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- run  in  1  level start; held high for the whole operation, low to abort/clear.
- d  in  N_CHAR*CHAR_LEN  character codes; char i = d[i*CHAR_LEN +: CHAR_LEN].
- valid  out  1  all N_CHAR embeddings captured.
- err  out  1  dense block failed to respond within TIMEOUT.
- busy  out  1  high in LOAD/RUN.
- q  out  N_CHAR*HID_DIM*N_LEN  embeddings; char i at q[i*HID_DIM*N_LEN +: HID_DIM*N_LEN].
- dense_run  out  1  run to dense block.
- dense_d  out  CHAR_LEN  character code to dense block.
- dense_valid  in  1  dense block valid.
- dense_q  in  HID_DIM*N_LEN  dense block embedding.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs, idx, wait counter, d_buf and q_buf are cleared.
  - State is IDLE.
- States: IDLE, LOAD, RUN, DONE, ERR.
- IDLE:
  - dense_run=0.
  - On run=1: latch d into d_buf, idx<=0, go to LOAD.
- LOAD (1 cycle):
  - dense_run=0, dense_d=d_buf[idx].
  - The dense block latches its address this cycle.
  - Go to RUN; wait counter <= 0.
- RUN:
  - dense_run=1, dense_d held at d_buf[idx]; wait counter increments each cycle.
  - On dense_valid=1: q_buf[idx] <= dense_q.
    - If idx==N_CHAR-1, go to DONE.
    - Otherwise idx<=idx+1 and go to LOAD.
  - If the wait counter reaches TIMEOUT without dense_valid, go to ERR.
- DONE:
  - valid=1, dense_run=0.
  - Stays in DONE while run=1.
- ERR:
  - err=1, dense_run=0.
  - Stays in ERR while run=1.
- run=0 in any state (abort):
  - Next state is IDLE; valid, err and busy go to 0; dense_run goes to 0 the same cycle (combinational from state and run).
  - idx and wait counter are cleared.
  - q_buf retains its contents; it is overwritten on the next run.
- Timing with default dense block (valid on 6th run-high cycle):
  - Each character takes 7 cycles (1 LOAD + 6 RUN).
  - valid rises 1+7*N_CHAR cycles after the first cycle run is sampled high (71 for N_CHAR=10).
- d changes after the IDLE->LOAD transition have no effect; only d_buf is used.
- dense_valid is ignored outside RUN.
- dense_valid in the same cycle the wait counter hits TIMEOUT: valid wins and the data is captured.
- q is driven directly from q_buf (registered, no combinational path from dense_q).
- busy = state is LOAD or RUN.

Test Plan:
- Reset mid-RUN (rst_n low 1 cycle while idx=4):
  - valid, err, busy, dense_run and q go to 0 immediately.
  - State returns to IDLE.
- Nominal, N_CHAR=10, d = codes 0..9, dense model returning element j of char c = {c[7:0], j[7:0]}:
  - valid rises exactly 71 cycles after run.
  - q slot c element j equals {c, j} for all c and j.
- Abort: drop run at cycle 30:
  - dense_run is 0 in the same cycle; valid never asserts.
  - Re-raise run with new codes: full new result, valid after 71 cycles.
- Input change: alter d one cycle after run rises:
  - Output reflects the originally latched codes.
  - dense_d sequence matches the latched codes.
- Timeout: dense model never asserts valid:
  - err rises TIMEOUT cycles into the first RUN and holds while run=1.
  - valid stays 0; run low clears err.
- Boundary codes d=255 and 0, plus dense_valid pulsed while in LOAD/IDLE:
  - Only RUN-phase valids are captured.
  - Slots for char 255 and char 0 are correct.

Source files
------------

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl
//   Walks a string of N_CHAR character codes through the dense embedding
//   block one character at a time. Each embedding is captured into its own
//   slot, and the full set is presented on q for the first hidden layer.
//   The handshake is level-held: run must stay high for the whole
//   operation, and dropping it aborts the operation and clears it.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   run          level start / hold; low aborts and returns to IDLE
//   d            N_CHAR packed codes, char i = d[i*CHAR_LEN +: CHAR_LEN]
//   valid        all embeddings captured (DONE)
//   err          dense block did not answer within TIMEOUT RUN cycles (ERR)
//   busy         sequencing in progress (LOAD or RUN)
//   q            embeddings, char i at q[i*HID_DIM*N_LEN +: HID_DIM*N_LEN]
//   dense_run    run to the dense block
//   dense_d      character code presented to the dense block
//   dense_valid  dense block result valid
//   dense_q      dense block embedding
module dense_seq_ctrl #(
  parameter int N_CHAR   = 10,
  parameter int CHAR_LEN = 8,
  parameter int HID_DIM  = 24,
  parameter int N_LEN    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  input  logic [N_CHAR*CHAR_LEN-1:0]       d,
  output logic                             valid,
  output logic                             err,
  output logic                             busy,
  output logic [N_CHAR*HID_DIM*N_LEN-1:0]  q,
  output logic                             dense_run,
  output logic [CHAR_LEN-1:0]              dense_d,
  input  logic                             dense_valid,
  input  logic [HID_DIM*N_LEN-1:0]         dense_q
);

  localparam int EMB_W  = HID_DIM * N_LEN;
  localparam int IDX_W  = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [CHAR_LEN-1:0]   d_buf [N_CHAR];
  logic [EMB_W-1:0]      q_buf [N_CHAR];

  logic last_char;
  logic timeout_hit;

  assign last_char   = (idx == IDX_W'(N_CHAR - 1));
  // The counter holds k-1 during the k-th RUN cycle, so TIMEOUT-1 marks the
  // last cycle the dense block is allowed to answer in.
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_LOAD;
        S_LOAD: state_nxt = S_RUN;
        S_RUN: begin
          // dense_valid wins over a simultaneous timeout
          if (dense_valid)      state_nxt = last_char ? S_DONE : S_LOAD;
          else if (timeout_hit) state_nxt = S_ERR;
        end
        S_DONE: state_nxt = S_DONE;
        S_ERR:  state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore on state; dense_run also gated by run so an abort stops
  // the dense block in the same cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    valid     = (state == S_DONE);
    err       = (state == S_ERR);
    busy      = (state == S_LOAD) || (state == S_RUN);
    dense_run = (state == S_RUN) && run;
    dense_d   = d_buf[idx];
  end

  // ---------------------------------------------------------------------------
  // Datapath: code buffer, character index, wait counter, embedding slots
  // ---------------------------------------------------------------------------
  // NOTE: d_buf and q_buf are register arrays, not RAM, and are cleared by
  // reset because q must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      wait_cnt <= '0;
      for (int i = 0; i < N_CHAR; i++) begin
        d_buf[i] <= '0;
        q_buf[i] <= '0;
      end
    end else if (!run) begin
      // Abort: q_buf keeps its contents until the next run overwrites it
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          for (int i = 0; i < N_CHAR; i++) d_buf[i] <= d[i*CHAR_LEN +: CHAR_LEN];
          idx <= '0;
        end
        S_LOAD: wait_cnt <= '0;
        S_RUN: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (dense_valid) begin
            q_buf[idx] <= dense_q;
            if (!last_char) idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_CHAR; g++) begin : g_q
    assign q[g*EMB_W +: EMB_W] = q_buf[g];
  end

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Self-checking bench for dense_seq_ctrl. A behavioural dense block answers
// after a programmable number of run-high cycles with element j of char c
// equal to {c, j}. Expected latencies come from the per-character cycle
// arithmetic (1 LOAD + latency RUN cycles); expected embeddings come from
// the character codes the bench applied.
module tb_dense_seq_ctrl;

  localparam int N_CHAR   = 10;
  localparam int CHAR_LEN = 8;
  localparam int HID_DIM  = 24;
  localparam int N_LEN    = 16;
  localparam int TIMEOUT  = 15;
  localparam int EMB_W    = HID_DIM * N_LEN;

  logic                            clk;
  logic                            rst_n;
  logic                            run;
  logic [N_CHAR*CHAR_LEN-1:0]      d;
  logic                            valid;
  logic                            err;
  logic                            busy;
  logic [N_CHAR*EMB_W-1:0]         q;
  logic                            dense_run;
  logic [CHAR_LEN-1:0]             dense_d;
  logic                            dense_valid;
  logic [EMB_W-1:0]                dense_q;

  int total = 0;
  int bad   = 0;

  // dense block model controls
  int   lat;       // answer on the lat-th run-high cycle, 0 = never
  int   run_cnt;
  logic glitch;    // forced dense_valid with garbage data

  logic [CHAR_LEN-1:0] codes      [N_CHAR];
  logic [CHAR_LEN-1:0] last_codes [N_CHAR];
  logic [CHAR_LEN-1:0] load_q [$];

  dense_seq_ctrl #(
    .N_CHAR(N_CHAR), .CHAR_LEN(CHAR_LEN), .HID_DIM(HID_DIM),
    .N_LEN(N_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .d(d),
    .valid(valid), .err(err), .busy(busy), .q(q),
    .dense_run(dense_run), .dense_d(dense_d),
    .dense_valid(dense_valid), .dense_q(dense_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EMB_W-1:0] emb(input logic [CHAR_LEN-1:0] c);
    logic [EMB_W-1:0] r;
    r = '0;
    for (int j = 0; j < HID_DIM; j++) r[j*N_LEN +: N_LEN] = {c, 8'(j)};
    return r;
  endfunction

  function automatic logic [N_CHAR*CHAR_LEN-1:0] pack_codes();
    logic [N_CHAR*CHAR_LEN-1:0] r;
    for (int i = 0; i < N_CHAR; i++) r[i*CHAR_LEN +: CHAR_LEN] = codes[i];
    return r;
  endfunction

  // Behavioural dense block
  always @(posedge clk) run_cnt <= dense_run ? run_cnt + 1 : 0;
  assign dense_valid = glitch | (dense_run && lat != 0 && run_cnt == lat - 1);
  always_comb dense_q = glitch ? {HID_DIM{16'hDEAD}} : emb(dense_d);

  // Record the code presented on the first RUN cycle of every character
  always @(posedge clk) if (dense_run && run_cnt == 0) load_q.push_back(dense_d);

  task automatic check(input string tag, input logic [EMB_W-1:0] obs,
                       input logic [EMB_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_q_codes(input string tag, input logic [CHAR_LEN-1:0] c [N_CHAR]);
    for (int s = 0; s < N_CHAR; s++)
      check($sformatf("%s_slot%0d", tag, s), q[s*EMB_W +: EMB_W], emb(c[s]));
  endtask

  task automatic check_q_zero(input string tag);
    for (int s = 0; s < N_CHAR; s++)
      check($sformatf("%s_slot%0d", tag, s), q[s*EMB_W +: EMB_W], '0);
  endtask

  function automatic int full_latency(input int l);
    return 1 + N_CHAR * (1 + l);
  endfunction

  // Run one full string with the current codes and lat, then release run.
  task automatic run_full(input string tag, input bit alter, input bit glitch_load);
    int n;
    bit seen;
    logic [CHAR_LEN-1:0] applied [N_CHAR];
    applied = codes;
    @(negedge clk);
    d = pack_codes();
    load_q.delete();
    run = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (alter && n == 1) d = ~d;
      if (glitch_load) glitch = (n == 1);
      seen = valid;
    end
    check({tag, "_latency"}, EMB_W'(n), EMB_W'(full_latency(lat)));
    check({tag, "_err_low"}, EMB_W'(err), '0);
    check_q_codes(tag, applied);
    check({tag, "_loads"}, EMB_W'(load_q.size()), EMB_W'(N_CHAR));
    for (int c = 0; c < N_CHAR && c < load_q.size(); c++)
      check($sformatf("%s_dense_d%0d", tag, c), EMB_W'(load_q[c]), EMB_W'(applied[c]));
    repeat (3) @(negedge clk);
    check({tag, "_valid_hold"}, EMB_W'(valid), EMB_W'(1));
    check({tag, "_busy_done"}, EMB_W'(busy), '0);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_clr"}, EMB_W'(valid), '0);
    last_codes = applied;
  endtask

  task automatic random_codes();
    for (int i = 0; i < N_CHAR; i++) codes[i] = CHAR_LEN'($urandom_range(0, 255));
  endtask

  initial begin
    int n;
    int hits;
    rst_n  = 1'b0;
    run    = 1'b0;
    d      = '0;
    glitch = 1'b0;
    lat    = 6;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_valid", EMB_W'(valid), '0);
    check("rst_err", EMB_W'(err), '0);
    check("rst_busy", EMB_W'(busy), '0);
    check("rst_dense_run", EMB_W'(dense_run), '0);
    check("rst_dense_d", EMB_W'(dense_d), '0);
    check_q_zero("rst_q");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", EMB_W'(busy), '0);

    // ---- nominal: codes 0..9 ----
    for (int i = 0; i < N_CHAR; i++) codes[i] = CHAR_LEN'(i);
    run_full("nominal", 1'b0, 1'b0);

    // ---- asynchronous reset in the middle of char 4 ----
    @(negedge clk);
    random_codes();
    d = pack_codes();
    run = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    // after edge m (counting from 0) the block is in LOAD iff m%7 == 0
    check("mid_rst_busy_before", EMB_W'(busy), EMB_W'(1));
    check("mid_rst_dense_run_before", EMB_W'(dense_run), EMB_W'((29 % 7) != 0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", EMB_W'(valid), '0);
    check("mid_rst_err", EMB_W'(err), '0);
    check("mid_rst_busy", EMB_W'(busy), '0);
    check("mid_rst_dense_run", EMB_W'(dense_run), '0);
    check_q_zero("mid_rst_q");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_idle_busy", EMB_W'(busy), '0);

    // ---- random codes ----
    random_codes();
    run_full("random", 1'b0, 1'b0);

    // ---- abort at cycle 30, then a fresh run ----
    random_codes();
    @(negedge clk);
    d = pack_codes();
    run = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("abort_dense_run_before", EMB_W'(dense_run), EMB_W'((29 % 7) != 0));
    run = 1'b0;
    #1;
    check("abort_dense_run_same_cycle", EMB_W'(dense_run), '0);
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", EMB_W'(busy), '0);
    hits = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (valid) hits++;
    end
    check("abort_valid_never", EMB_W'(hits), '0);
    random_codes();
    run_full("rerun", 1'b0, 1'b0);

    // ---- d changes after the IDLE->LOAD transition ----
    random_codes();
    run_full("alter_d", 1'b1, 1'b0);

    // ---- dense answers exactly on the timeout cycle: capture wins ----
    lat = TIMEOUT;
    random_codes();
    run_full("edge_timeout", 1'b0, 1'b0);
    lat = 6;

    // ---- timeout: dense block never answers ----
    lat = 0;
    @(negedge clk);
    run = 1'b1;
    n = 0;
    while (!err && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("timeout_latency", EMB_W'(n), EMB_W'(2 + TIMEOUT));
    check("timeout_valid", EMB_W'(valid), '0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (err && !valid && !busy && !dense_run) hits++;
    end
    check("timeout_err_hold", EMB_W'(hits), EMB_W'(5));
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("timeout_err_clr", EMB_W'(err), '0);
    check_q_codes("timeout_q_kept", last_codes);
    lat = 6;

    // ---- boundary codes with dense_valid pulsed in IDLE and LOAD ----
    glitch = 1'b1;
    repeat (2) @(negedge clk);
    glitch = 1'b0;
    check_q_codes("idle_glitch_q", last_codes);
    random_codes();
    codes[0] = 8'd255;
    codes[1] = 8'd0;
    codes[N_CHAR-1] = 8'd255;
    run_full("boundary", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
